// File: rtl/instr_mem_responder.sv
// instr_mem_responder: fixed-latency instruction memory with a preload write port.
// Fetches are granted up to MAX_OUTSTANDING deep and answered strictly in acceptance order.
module instr_mem_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int unsigned LATENCY         = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         instr_req_i,
    input  logic [31:0]                  instr_addr_i,
    output logic                         instr_gnt_o,
    output logic                         instr_rvalid_o,
    output logic [31:0]                  instr_rdata_o,
    output logic                         instr_err_o,
    input  logic                         gnt_hold_i,
    input  logic                         load_we_i,
    input  logic [$clog2(MEM_WORDS)-1:0] load_addr_i,
    input  logic [31:0]                  load_data_i
);
    localparam int unsigned AW = $clog2(MEM_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   mem [MEM_WORDS];
    logic [CW-1:0] outstanding_q;
    logic [63:0]   offset;
    logic [AW-1:0] index;
    logic          in_range;
    logic          accept;
    logic [31:0]   fetch_data;

    logic          pipe_valid [LATENCY];
    logic          pipe_err   [LATENCY];
    logic [31:0]   pipe_data  [LATENCY];

    // 64-bit offset keeps the range test free of wrap-around near the top of the address space.
    always_comb begin
        offset      = 64'(instr_addr_i) - 64'(BASE_ADDR);
        in_range    = (instr_addr_i >= BASE_ADDR) && (offset < (64'(MEM_WORDS) * 64'd4));
        index       = AW'(offset >> 2);
        fetch_data  = in_range ? mem[index] : '0;
        instr_gnt_o = instr_req_i && !gnt_hold_i && (outstanding_q < CW'(MAX_OUTSTANDING));
        accept      = instr_gnt_o;
    end

    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    // Non-accept slots carry zero data so the response outputs are zero whenever rvalid is low.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_err[i]   <= 1'b0;
                pipe_data[i]  <= '0;
            end
        end else begin
            pipe_valid[0] <= accept;
            pipe_err[0]   <= accept && !in_range;
            pipe_data[0]  <= accept ? fetch_data : '0;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_err[i]   <= pipe_err[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    always_comb begin
        instr_rvalid_o = pipe_valid[LATENCY-1];
        instr_err_o    = pipe_err[LATENCY-1];
        instr_rdata_o  = pipe_data[LATENCY-1];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding_q <= '0;
        end else if (accept && !instr_rvalid_o) begin
            outstanding_q <= outstanding_q + CW'(1);
        end else if (!accept && instr_rvalid_o) begin
            outstanding_q <= outstanding_q - CW'(1);
        end
    end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder: per-cycle comparison against a queue-based
// response model, directed literal scenarios, then randomized traffic with occasional resets.
module tb_instr_mem_responder;
    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned LAT       = 2;
    localparam int unsigned MAX_OUT   = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        instr_err_o;
    logic        gnt_hold_i;
    logic        load_we_i;
    logic [9:0]  load_addr_i;
    logic [31:0] load_data_i;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       pending[$];
    logic [31:0] shadow [MEM_WORDS];

    instr_mem_responder #(
        .MEM_WORDS(MEM_WORDS),
        .BASE_ADDR(32'h0),
        .LATENCY(LAT),
        .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .instr_req_i(instr_req_i),
        .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .instr_err_o(instr_err_o),
        .gnt_hold_i(gnt_hold_i),
        .load_we_i(load_we_i),
        .load_addr_i(load_addr_i),
        .load_data_i(load_data_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a fetch is a word lookup with a range test, answered LAT cycles later.
    always @(negedge clk) begin
        logic        exp_rv;
        logic        exp_gnt;
        logic [31:0] exp_data;
        logic        exp_err;
        longint      a;
        resp_t       r;
        cyc++;
        if (!rstn) pending.delete();
        exp_rv   = rstn && pending.size() > 0 && pending[0].due == cyc;
        exp_data = exp_rv ? pending[0].data : 32'h0;
        exp_err  = exp_rv ? pending[0].err : 1'b0;
        exp_gnt  = instr_req_i && !gnt_hold_i && (pending.size() < MAX_OUT);
        check("gnt", 32'(instr_gnt_o), 32'(exp_gnt));
        check("rvalid", 32'(instr_rvalid_o), 32'(exp_rv));
        check("rdata", instr_rdata_o, exp_data);
        check("err", 32'(instr_err_o), 32'(exp_err));
        if (rstn) begin
            if (exp_rv) void'(pending.pop_front());
            if (exp_gnt) begin
                a     = longint'(instr_addr_i);
                r.due = cyc + LAT;
                r.err = !(a < MEM_WORDS * 4);
                r.data = r.err ? 32'h0 : shadow[a / 4];
                pending.push_back(r);
            end
        end
        if (load_we_i) shadow[load_addr_i] = load_data_i;
    end

    task automatic tick(input logic req, input logic [31:0] addr, input logic hold);
        @(posedge clk); #1;
        instr_req_i  = req;
        instr_addr_i = addr;
        gnt_hold_i   = hold;
        load_we_i    = 1'b0;
        @(negedge clk);
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        @(posedge clk); #1;
        instr_req_i = 1'b0;
        gnt_hold_i  = 1'b0;
        load_we_i   = 1'b1;
        load_addr_i = 10'(idx);
        load_data_i = data;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] addrs [4];
        logic        gnt_pat [4];
        logic        rv_pat [7];
        logic [31:0] rd_pat [7];
        addrs   = '{32'h0, 32'h4, 32'h8, 32'h8};
        gnt_pat = '{1'b1, 1'b1, 1'b0, 1'b1};
        rv_pat  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        rd_pat  = '{32'h0, 32'h0, 32'h00000013, 32'hABCD0001, 32'h0, 32'hDEAD0002, 32'h0};

        rstn = 1'b0; instr_req_i = 1'b0; instr_addr_i = '0; gnt_hold_i = 1'b0;
        load_we_i = 1'b0; load_addr_i = '0; load_data_i = '0;
        #2;
        check("reset_rvalid", 32'(instr_rvalid_o), 32'h0);
        check("reset_rdata", instr_rdata_o, 32'h0);
        check("reset_err", 32'(instr_err_o), 32'h0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        for (int i = 0; i < MEM_WORDS; i++) preload(i, $urandom);
        preload(0, 32'h00000013);
        preload(1, 32'hABCD0001);
        preload(2, 32'hDEAD0002);
        idle(2);

        // Single fetch, response exactly LAT cycles after acceptance.
        tick(1'b1, 32'h0, 1'b0);
        check("d035_gnt", 32'(instr_gnt_o), 32'h1);
        for (int c = 1; c <= 3; c++) begin
            tick(1'b0, 32'h0, 1'b0);
            check("d035_rvalid", 32'(instr_rvalid_o), 32'(c == 2));
            if (c == 2) begin
                check("d035_rdata", instr_rdata_o, 32'h00000013);
                check("d035_err", 32'(instr_err_o), 32'h0);
            end
        end
        idle(2);

        // Back-to-back fetches saturating the outstanding limit.
        for (int c = 0; c < 7; c++) begin
            tick(c < 4, c < 4 ? addrs[c] : 32'h0, 1'b0);
            if (c < 4) check("d036_gnt", 32'(instr_gnt_o), 32'(gnt_pat[c]));
            check("d036_rvalid", 32'(instr_rvalid_o), 32'(rv_pat[c]));
            check("d036_rdata", instr_rdata_o, rd_pat[c]);
        end
        idle(2);

        // Out-of-range and unaligned fetches.
        tick(1'b1, 32'h1000, 1'b0);
        check("d037_gnt", 32'(instr_gnt_o), 32'h1);
        tick(1'b1, 32'h6, 1'b0);
        tick(1'b0, 32'h0, 1'b0);
        check("d037_rvalid", 32'(instr_rvalid_o), 32'h1);
        check("d037_err", 32'(instr_err_o), 32'h1);
        check("d037_rdata", instr_rdata_o, 32'h0);
        tick(1'b0, 32'h0, 1'b0);
        check("d038_rdata", instr_rdata_o, 32'hABCD0001);
        check("d038_err", 32'(instr_err_o), 32'h0);
        idle(2);

        // Backpressure holds off grants; release grants in the same cycle.
        for (int c = 0; c < 5; c++) begin
            tick(1'b1, 32'h4, 1'b1);
            check("d039_gnt_held", 32'(instr_gnt_o), 32'h0);
            check("d039_rvalid", 32'(instr_rvalid_o), 32'h0);
        end
        tick(1'b1, 32'h4, 1'b0);
        check("d039_gnt_release", 32'(instr_gnt_o), 32'h1);
        idle(3);

        // Reset with two responses in flight discards them.
        tick(1'b1, 32'h0, 1'b0);
        tick(1'b1, 32'h4, 1'b0);
        check("d040_gnt2", 32'(instr_gnt_o), 32'h1);
        @(posedge clk); #1;
        rstn = 1'b0; instr_req_i = 1'b0;
        #1 check("d040_rvalid_async", 32'(instr_rvalid_o), 32'h0);
        @(negedge clk);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, 32'h0, 1'b0);
            check("d040_no_rvalid", 32'(instr_rvalid_o), 32'h0);
        end
        tick(1'b1, 32'h8, 1'b0);
        check("d040_post_gnt", 32'(instr_gnt_o), 32'h1);
        idle(3);

        // Randomized traffic with preload writes, backpressure and rare resets.
        for (int n = 0; n < 4000; n++) begin
            int sel;
            @(posedge clk); #1;
            rstn        = ($urandom_range(0, 299) != 0);
            instr_req_i = ($urandom_range(0, 9) < 7);
            gnt_hold_i  = ($urandom_range(0, 9) < 2);
            load_we_i   = ($urandom_range(0, 9) < 3);
            load_addr_i = 10'($urandom_range(0, MEM_WORDS - 1));
            load_data_i = $urandom;
            sel = $urandom_range(0, 9);
            if (sel < 7)       instr_addr_i = 32'($urandom_range(0, 4095));
            else if (sel < 9)  instr_addr_i = 32'h1000 + 32'($urandom_range(0, 65535));
            else begin
                case ($urandom_range(0, 3))
                    0:       instr_addr_i = 32'hFFC;
                    1:       instr_addr_i = 32'h1000;
                    2:       instr_addr_i = 32'hFFFF_FFFF;
                    default: instr_addr_i = $urandom;
                endcase
            end
        end
        @(posedge clk); #1;
        rstn = 1'b1; load_we_i = 1'b0;
        idle(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
